approx_rec_mult_seq: RTL and testbench

Iterative, parametrised recursive multiplier that computes a WIDTH x WIDTH product by walking all 4x4 nibble leaves, one per clock, through a single leaf multiplier and shift-accumulating the results. A per-transaction mode input selects exact or approximate operation. In approximate mode, low-weight leaves are replaced by a cheap approximate leaf. It is the sequential, area-lean successor to the combinational 8x8 recursive multipliers and uses valid/ready handshakes on input and output.

---
 rtl/approx_rec_mult_seq.sv | 178 +++++++++++++++++
 tb/tb_approx_rec_mult_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_rec_mult_seq.sv
// approx_rec_mult_seq
// -------------------
// Sequential recursive multiplier. A WIDTH x WIDTH unsigned product is built by
// visiting every 4x4 nibble leaf (i,j) once, one leaf per clock, through a
// single 4x4 leaf multiplier. Each leaf product is shifted by 4*(i+j) and added
// into a 2*WIDTH accumulator. In approximate mode the low-weight leaves
// (i+j < APPROX_THRESH) replace the low nibble of their product with the
// bitwise OR of the two operand nibbles.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands and mode valid
//   in_ready   block is idle and can accept operands
//   a, b       unsigned operands (WIDTH bits)
//   approx     1 = approximate mode, 0 = exact; sampled with the operands
//   out_valid  y holds a finished product
//   out_ready  consumer accepts y
//   y          unsigned product (2*WIDTH bits), held after the handshake
//   busy       high while leaves are being accumulated

module approx_rec_mult_seq #(
    parameter int WIDTH         = 16,
    parameter int APPROX_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 approx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    // The largest leaf index sum is 2N-2, so clamping the threshold to 2N-1
    // keeps the comparison constant representable without changing behaviour.
    localparam int THR_LO = (APPROX_THRESH < 0) ? 0 : APPROX_THRESH;
    localparam int THR    = (THR_LO > 2 * N - 1) ? 2 * N - 1 : THR_LO;

    localparam logic [IW-1:0] NIB_LAST = IW'(N - 1);
    localparam logic [IW-1:0] NIB_ONE  = IW'(1);
    localparam logic [IW:0]   THR_V    = (IW + 1)'(THR);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opA_q, opA_d;
    logic [WIDTH-1:0]  opB_q, opB_d;
    logic              approx_q, approx_d;
    logic [IW-1:0]     nibI_q, nibI_d;
    logic [IW-1:0]     nibJ_q, nibJ_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     y_q, y_d;

    logic              lastLeaf;
    logic [3:0]        nibA;
    logic [3:0]        nibB;
    logic [IW:0]       leafSum;
    logic [7:0]        leafExact;
    logic              useApprox;
    logic [7:0]        leafProd;
    logic [PW-1:0]     leafShifted;

    // Leaf datapath: select the current nibble pair, form the (possibly
    // approximated) 8-bit leaf product and align it to weight 16^(i+j).
    always_comb begin
        lastLeaf    = (nibI_q == NIB_LAST) && (nibJ_q == NIB_LAST);
        nibA        = 4'(opA_q >> {nibI_q, 2'b00});
        nibB        = 4'(opB_q >> {nibJ_q, 2'b00});
        leafSum     = {1'b0, nibI_q} + {1'b0, nibJ_q};
        leafExact   = {4'b0000, nibA} * {4'b0000, nibB};
        useApprox   = approx_q && (leafSum < THR_V);
        leafProd    = useApprox ? {leafExact[7:4], nibA | nibB} : leafExact;
        leafShifted = {{(PW - 8){1'b0}}, leafProd} << {leafSum, 2'b00};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Input is only looked at in IDLE and out_ready only in
    // DONE, so a source holding in_valid while we work is simply ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (lastLeaf)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: handshake and status flags decode straight from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == BUSY);
        out_valid = (state_q == DONE);
        y         = y_q;
    end

    // Datapath next-state. Leaves are walked with j (b nibble) as the fast
    // index. y gets its own register so it keeps the last product in IDLE
    // even after the accumulator is cleared for a new transaction.
    always_comb begin
        opA_d    = opA_q;
        opB_d    = opB_q;
        approx_d = approx_q;
        nibI_d   = nibI_q;
        nibJ_d   = nibJ_q;
        acc_d    = acc_q;
        y_d      = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d    = a;
                    opB_d    = b;
                    approx_d = approx;
                    acc_d    = '0;
                    nibI_d   = '0;
                    nibJ_d   = '0;
                end
            end
            BUSY: begin
                acc_d = acc_q + leafShifted;
                if (nibJ_q == NIB_LAST) begin
                    nibJ_d = '0;
                    nibI_d = lastLeaf ? '0 : nibI_q + NIB_ONE;
                end else begin
                    nibJ_d = nibJ_q + NIB_ONE;
                end
                if (lastLeaf) begin
                    y_d = acc_q + leafShifted;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA_q    <= '0;
            opB_q    <= '0;
            approx_q <= 1'b0;
            nibI_q   <= '0;
            nibJ_q   <= '0;
            acc_q    <= '0;
            y_q      <= '0;
        end else begin
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            approx_q <= approx_d;
            nibI_q   <= nibI_d;
            nibJ_q   <= nibJ_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
        end
    end

endmodule

// File: tb/tb_approx_rec_mult_seq.sv
// tb_approx_rec_mult_seq
// ----------------------
// Self-checking bench for approx_rec_mult_seq at WIDTH=16 and WIDTH=8.
// Expected products are queued when operands are accepted and compared when
// the design hands out a result.

module tb_approx_rec_mult_seq;

    localparam int TH = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv16, ir16, ap16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] y16;

    logic        iv8, ir8, ap8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] y8;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb16[$];
    logic [15:0] sb8[$];

    // Free-running clock shared by both instances.
    always #5 clk = ~clk;

    approx_rec_mult_seq #(.WIDTH(16), .APPROX_THRESH(TH)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .approx(ap16),
        .out_valid(ov16), .out_ready(or16),
        .y(y16), .busy(busy16)
    );

    approx_rec_mult_seq #(.WIDTH(8), .APPROX_THRESH(TH)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .approx(ap8),
        .out_valid(ov8), .out_ready(or8),
        .y(y8), .busy(busy8)
    );

    // Reference product built leaf by leaf; the low nibble of each
    // approximated leaf is the OR of its operand nibbles.
    function automatic logic [31:0] golden(input logic [15:0] ga, input logic [15:0] gb,
                                           input logic gap, input int w);
        logic [63:0] acc;
        logic [3:0]  an;
        logic [3:0]  bn;
        logic [7:0]  p;
        int          n;
        acc = '0;
        n   = w / 4;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                an = ga[4*i +: 4];
                bn = gb[4*j +: 4];
                p  = 8'(an) * 8'(bn);
                if (gap && (i + j < TH)) p[3:0] = an | bn;
                acc = acc + (64'(p) << (4 * (i + j)));
            end
        end
        if (w == 16) return acc[31:0];
        return {16'h0000, acc[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present operands until accepted; expected result goes on the scoreboard.
    task automatic applyStimulus16(input logic [15:0] sa, input logic [15:0] sb,
                                   input logic sap, input logic [31:0] expected, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        a16 = sa; b16 = sb; ap16 = sap; iv16 = 1'b1;
        n = 0;
        while (!ir16 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) checkOutput("accept16_timeout", 32'(ir16), 32'd1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        sb16.push_back(expected);
    endtask

    task automatic applyStimulus8(input logic [7:0] sa, input logic [7:0] sb,
                                  input logic sap, input logic [15:0] expected, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        a8 = sa; b8 = sb; ap8 = sap; iv8 = 1'b1;
        n = 0;
        while (!ir8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) checkOutput("accept8_timeout", 32'(ir8), 32'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        sb8.push_back(expected);
    endtask

    // Wait for a result, optionally wiggling out_ready, and compare on the
    // handshake cycle against the oldest scoreboard entry.
    task automatic collectOutput16(input string tag, input bit randReady);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            or16 = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ov16 && or16) begin
                checkOutput(tag, y16, sb16.pop_front());
                @(posedge clk); #1;
                or16 = 1'b0;
                done = 1'b1;
            end
            n++;
        end
        if (!done) begin
            checkOutput({tag, "_timeout"}, 32'(ov16), 32'd1);
            @(posedge clk); #1;
            or16 = 1'b0;
        end
    endtask

    task automatic collectOutput8(input string tag, input bit randReady);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            or8 = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ov8 && or8) begin
                checkOutput(tag, {16'h0000, y8}, {16'h0000, sb8.pop_front()});
                @(posedge clk); #1;
                or8 = 1'b0;
                done = 1'b1;
            end
            n++;
        end
        if (!done) begin
            checkOutput({tag, "_timeout"}, 32'(ov8), 32'd1);
            @(posedge clk); #1;
            or8 = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] held;
        logic [15:0] ra, rb;
        logic        rap;
        logic [7:0]  ra8, rb8;

        rst_n = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; ap16 = 1'b0; or16 = 1'b0;
        iv8  = 1'b0; a8  = '0; b8  = '0; ap8  = 1'b0; or8  = 1'b0;

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(ir16), 32'd1);
        checkOutput("rst_out_valid", 32'(ov16), 32'd0);
        checkOutput("rst_busy", 32'(busy16), 32'd0);
        checkOutput("rst_y", y16, 32'd0);
        checkOutput("rst_y8", {16'h0000, y8}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Exact small product with latency measured from the accept edge.
        applyStimulus16(16'd3, 16'd5, 1'b0, 32'd15, 0);
        checkOutput("busy_after_accept", 32'(busy16), 32'd1);
        lat = 0;
        while (!ov16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency16", 32'(lat), 32'd16);
        collectOutput16("exact_small", 1'b0);

        // Approx 3*5: leaf (0,0) gives 7, and the off-diagonal low-weight
        // leaves OR in their non-zero nibble: 3<<4 and 5<<4, total 0x87.
        applyStimulus16(16'd3, 16'd5, 1'b1, 32'h0000_0087, 1);
        collectOutput16("approx_small", 1'b0);

        // All-ones corner in both modes.
        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 0);
        collectOutput16("corner_exact", 1'b0);
        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_01CF, 0);
        collectOutput16("corner_approx", 1'b0);

        // Backpressure: result must sit still while out_ready is low.
        applyStimulus16(16'h00AB, 16'h0CD0, 1'b0, 32'h0008_8EF0, 0);
        lat = 0;
        while (!ov16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        held = sb16.pop_front();
        checkOutput("bp_y_first", y16, held);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput("bp_y_hold", y16, held);
            checkOutput("bp_in_ready_low", 32'(ir16), 32'd0);
            checkOutput("bp_out_valid_high", 32'(ov16), 32'd1);
        end
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        checkOutput("bp_in_ready_back", 32'(ir16), 32'd1);
        checkOutput("bp_out_valid_drop", 32'(ov16), 32'd0);
        checkOutput("bp_y_kept", y16, held);

        // Reset while leaf 7 is being processed; the transaction is dropped.
        applyStimulus16(16'h5555, 16'h7777, 1'b1, 32'd0, 0);
        repeat (7) begin
            @(posedge clk); #1;
        end
        checkOutput("midop_busy_before", 32'(busy16), 32'd1);
        rst_n = 1'b0;
        #1;
        sb16.delete();
        checkOutput("midop_in_ready", 32'(ir16), 32'd1);
        checkOutput("midop_out_valid", 32'(ov16), 32'd0);
        checkOutput("midop_busy", 32'(busy16), 32'd0);
        checkOutput("midop_y", y16, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus16(16'h1234, 16'h0010, 1'b0, 32'h0001_2340, 0);
        collectOutput16("after_reset", 1'b0);

        // WIDTH=8 directed corners.
        applyStimulus8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
        collectOutput8("w8_corner_exact", 1'b0);
        applyStimulus8(8'hFF, 8'hFF, 1'b1, 16'hFFCF, 0);
        collectOutput8("w8_corner_approx", 1'b0);

        // Random traffic with idle gaps and a wobbling out_ready.
        for (int t = 0; t < 150; t++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rap = 1'($urandom_range(0, 1));
            applyStimulus16(ra, rb, rap, golden(ra, rb, rap, 16), $urandom_range(0, 3));
            collectOutput16("rand16", 1'b1);
        end
        for (int t = 0; t < 150; t++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            rap = 1'($urandom_range(0, 1));
            applyStimulus8(ra8, rb8, rap, golden({8'h00, ra8}, {8'h00, rb8}, rap, 8)[15:0],
                           $urandom_range(0, 3));
            collectOutput8("rand8", 1'b1);
        end

        $display("[TB] random phase complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
